// File: rtl/usr_deser_pkg.sv
// Shared constants and helpers for the serial-to-parallel receiver.
package usr_deser_pkg;

    localparam bit BIT_ORDER_MSB_FIRST = 1'b1;
    localparam bit BIT_ORDER_LSB_FIRST = 1'b0;

    // Bit counter width: ceil(log2(n)), never less than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/usr_deser_sipo_core.sv
// Shift register plus bit counter; flags the cycle on which the Nth bit completes a word.
module usr_sipo_core
    import usr_deser_pkg::*;
#(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          S_in,
    input  logic          S_vld,
    input  logic          S_clr,
    output logic [N-1:0]  word,
    output logic          done,
    output logic [CW-1:0] cnt
);

    logic [N-1:0] s_reg;
    logic [N-1:0] shifted;
    logic         accept;
    logic         last;

    generate
        if (MSB_FIRST == BIT_ORDER_MSB_FIRST) begin : g_msb
            assign shifted = {s_reg[N-2:0], S_in};
        end else begin : g_lsb
            assign shifted = {S_in, s_reg[N-1:1]};
        end
    endgenerate

    assign accept = S_vld && !S_clr;
    assign last   = (cnt == CW'(N - 1));
    // The word is the shifted value including the current bit, so it is ready on the same edge.
    assign word   = shifted;
    assign done   = accept && last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_reg <= '0;
            cnt   <= '0;
        end else if (S_clr) begin
            s_reg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            s_reg <= shifted;
            cnt   <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/usr_deser.sv
// Serial-to-parallel receiver: SIPO core feeding a one-deep valid/ready output buffer.
//
//   state     | meaning
//   BUF_EMPTY | no unconsumed word, D_vld=0
//   BUF_FULL  | D_out holds an unconsumed word, D_vld=1
module usr_deser
    import usr_deser_pkg::*;
#(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         S_in,
    input  logic         S_vld,
    input  logic         S_clr,
    output logic [N-1:0] D_out,
    output logic         D_vld,
    input  logic         D_rdy,
    output logic         busy,
    output logic         ovf
);

    localparam int CW = cnt_width(N);

    buf_state_t    state, state_nxt;
    logic [N-1:0]  word;
    logic          done;
    logic [CW-1:0] cnt;
    logic          load;
    logic          ovf_set;

    usr_sipo_core #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .S_in  (S_in),
        .S_vld (S_vld),
        .S_clr (S_clr),
        .word  (word),
        .done  (done),
        .cnt   (cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (done) begin
                    load      = 1'b1;
                    state_nxt = BUF_FULL;
                end
            end
            BUF_FULL: begin
                // A completion with a pop replaces the word in place; without a pop it is lost.
                if (done) begin
                    if (D_rdy) load    = 1'b1;
                    else       ovf_set = 1'b1;
                end else if (D_rdy) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            D_out <= '0;
        end else if (load) begin
            D_out <= word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (S_clr) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end
    end

    assign D_vld = (state == BUF_FULL);
    assign busy  = (cnt != '0);

endmodule
